ram_lsu: RTL and testbench



---
 rtl/ram_lsu_if.sv | 36 +++
 rtl/ram_lsu.sv | 140 ++++++++++++++
 tb/tb_ram_lsu.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_lsu_if.sv
// Request/response channel from the memory stage plus the RAM master port of the LSU.
// Latency: none, wiring only.
// Backpressure: req_* and rsp_* are valid/ready pairs; the RAM port is not backpressured.
interface ram_lsu_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_en_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    // master: the LSU itself, which masters the RAM port
    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, ram_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output ram_en_o, ram_addr_o, ram_we_o, ram_data_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, ram_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  ram_en_o, ram_addr_o, ram_we_o, ram_data_o
    );
endinterface

// File: rtl/ram_lsu.sv
// Byte/half/word load-store initiator driving one data-RAM port; rejects misaligned/out-of-range.
// Latency from accept: error 1 cycle, store 2 cycles, load 3 cycles to rsp_valid_o.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held until rsp_ready_i.
module ram_lsu #(
    parameter int unsigned DATA_DEPTH = 8192,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic      clk_i,
    input  logic      rst_i,
    ram_lsu_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    localparam logic [32:0] LIMIT = 33'(DATA_DEPTH) << 2;

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  addr_lo_q;
    logic [29:0] widx_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] off_in;
    logic        illegal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    // Range check is done on a 33-bit compare so addresses near 2^32 cannot wrap into range.
    always_comb begin
        off_in  = bus.req_addr_i - BASE_ADDR;
        illegal = (bus.req_size_i == 2'b11)
               || (bus.req_size_i == 2'b01 && bus.req_addr_i[0])
               || (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00)
               || (bus.req_addr_i < BASE_ADDR)
               || ({1'b0, off_in} >= LIMIT);
    end

    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo_q)
            2'd0:    ld_byte = bus.ram_data_i[7:0];
            2'd1:    ld_byte = bus.ram_data_i[15:8];
            2'd2:    ld_byte = bus.ram_data_i[23:16];
            default: ld_byte = bus.ram_data_i[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus.ram_data_i[31:16] : bus.ram_data_i[15:0];
        ld_val  = bus.ram_data_i;
        if (size_q == 2'b00)
            ld_val = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        else if (size_q == 2'b01)
            ld_val = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_lo_q <= 2'b00;
            widx_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid_i) begin
                we_q      <= bus.req_we_i;
                size_q    <= bus.req_size_i;
                uns_q     <= bus.req_unsigned_i;
                addr_lo_q <= bus.req_addr_i[1:0];
                widx_q    <= off_in[31:2];
                wdata_q   <= bus.req_wdata_i;
                rdata_q   <= '0;
                err_q     <= illegal;
            end
            if (state_q == CAPTURE)
                rdata_q <= ld_val;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 4'b0000;
        bus.ram_addr_o  = '0;
        bus.ram_data_o  = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i)
                    state_d = illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.ram_en_o   = 1'b1;
                bus.ram_addr_o = {2'b00, widx_q};
                if (we_q) begin
                    case (size_q)
                        2'b00: begin
                            bus.ram_we_o   = 4'b0001 << addr_lo_q;
                            bus.ram_data_o = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            bus.ram_we_o   = 4'b0011 << addr_lo_q;
                            bus.ram_data_o = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            bus.ram_we_o   = 4'b1111;
                            bus.ram_data_o = wdata_q;
                        end
                    endcase
                    state_d = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: state_d = RESP;
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A reset landing on the ACCESS cycle must not let the RAM commit anything at that edge.
        if (rst_i) begin
            bus.ram_en_o = 1'b0;
            bus.ram_we_o = 4'b0000;
        end
    end

    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: behavioural RAM, vector table with response scoreboard,
// plus backpressure and mid-load reset sequences.
module tb_ram_lsu;
    localparam int DEPTH = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_lsu_if bus();

    ram_lsu #(.DATA_DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q = 32'h0;
    assign bus.ram_data_i = rd_q;

    always @(posedge clk) begin
        if (bus.ram_en_o && bus.ram_addr_o < DEPTH) begin
            rd_q <= mem[bus.ram_addr_o[12:0]];
            for (int i = 0; i < 4; i++)
                if (bus.ram_we_o[i])
                    mem[bus.ram_addr_o[12:0]][8*i +: 8] <= bus.ram_data_o[8*i +: 8];
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_we;
        logic [31:0] exp_data;
        logic [31:0] exp_waddr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [3:0] exp_we, input logic [31:0] exp_data,
                                input logic [31:0] exp_waddr);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_we = exp_we;
        v.exp_data = exp_data; v.exp_waddr = exp_waddr;
        vecs.push_back(v);
    endfunction

    task automatic drive_req(input vec_t v);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = v.we;
        bus.req_size_i     = v.size;
        bus.req_unsigned_i = v.uns;
        bus.req_addr_i     = v.addr;
        bus.req_wdata_i    = v.wdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, {31'h0, bus.req_ready_o}, 32'h1);
        chk({tag, " rsp_valid"}, {31'h0, bus.rsp_valid_o}, 32'h0);
        chk({tag, " rsp_rdata"}, bus.rsp_rdata_o, 32'h0);
        chk({tag, " rsp_err"},   {31'h0, bus.rsp_err_o}, 32'h0);
        chk({tag, " ram_en"},    {31'h0, bus.ram_en_o}, 32'h0);
        chk({tag, " ram_we"},    {28'h0, bus.ram_we_o}, 32'h0);
        chk({tag, " ram_addr"},  bus.ram_addr_o, 32'h0);
        chk({tag, " ram_data"},  bus.ram_data_o, 32'h0);
    endtask

    // Issue one request with rsp_ready held high and score the response.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        int          lat;
        int          en_seen;
        logic [3:0]  owe;
        logic [31:0] oadr, odat;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        owe = '0; oadr = '0; odat = '0;
        drive_req(v);
        chk({tag, " req_ready"}, {31'h0, bus.req_ready_o}, 32'h1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_err ? 1 : (v.we ? 2 : 3);
        sb.push_back(e);
        en_seen = 0;
        lat     = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.ram_en_o) begin
                en_seen++;
                owe  = bus.ram_we_o;
                oadr = bus.ram_addr_o;
                odat = bus.ram_data_o;
            end
            if (bus.rsp_valid_o) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: no rsp_valid within 20 cycles", tag);
        end else begin
            chk({tag, " latency"}, lat, e.lat);
            chk({tag, " rdata"}, bus.rsp_rdata_o, e.rdata);
            chk({tag, " err"}, {31'h0, bus.rsp_err_o}, {31'h0, e.err});
        end
        chk({tag, " en_count"}, en_seen, v.exp_err ? 0 : 1);
        if (!v.exp_err) begin
            chk({tag, " ram_we"}, {28'h0, owe}, {28'h0, v.exp_we});
            chk({tag, " ram_addr"}, oadr, v.exp_waddr);
            if (v.we) chk({tag, " ram_data"}, odat, v.exp_data);
        end
        @(posedge clk); #1;
        chk({tag, " rsp_cleared"}, {31'h0, bus.rsp_valid_o}, 32'h0);
    endtask

    initial begin
        vec_t v;
        exp_t e;
        int   lat;

        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
        bus.rsp_ready_i = 1'b1;

        //   we size uns addr          wdata          rdata          err we       data           waddr
        add(1, 2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0, 4'b1111, 32'hDEAD_BEEF, 32'd4);
        add(0, 2, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 4'b0000, 32'h0,         32'd4);
        add(1, 0, 0, 32'h0000_0013, 32'h0000_0080, 32'h0000_0000, 0, 4'b1000, 32'h8080_8080, 32'd4);
        add(0, 0, 0, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 0, 4'b0000, 32'h0,         32'd4);
        add(0, 0, 1, 32'h0000_0013, 32'h0,         32'h0000_0080, 0, 4'b0000, 32'h0,         32'd4);
        add(0, 0, 0, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 0, 4'b0000, 32'h0,         32'd4);
        add(1, 2, 0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 0, 4'b1111, 32'h0000_0000, 32'd8);
        add(1, 1, 0, 32'h0000_0022, 32'h1234_BEEF, 32'h0000_0000, 0, 4'b1100, 32'hBEEF_BEEF, 32'd8);
        add(0, 1, 0, 32'h0000_0022, 32'h0,         32'hFFFF_BEEF, 0, 4'b0000, 32'h0,         32'd8);
        add(0, 1, 1, 32'h0000_0022, 32'h0,         32'h0000_BEEF, 0, 4'b0000, 32'h0,         32'd8);
        add(0, 2, 0, 32'h0000_0020, 32'h0,         32'hBEEF_0000, 0, 4'b0000, 32'h0,         32'd8);
        add(0, 0, 0, 32'h0000_0023, 32'h0,         32'hFFFF_FFBE, 0, 4'b0000, 32'h0,         32'd8);
        add(0, 2, 0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1, 4'b0000, 32'h0,         32'd0);
        add(1, 2, 0, 32'h0000_8000, 32'h1111_1111, 32'h0000_0000, 1, 4'b0000, 32'h0,         32'd0);
        add(1, 2, 0, 32'h0000_7FFC, 32'hA5A5_5A5A, 32'h0000_0000, 0, 4'b1111, 32'hA5A5_5A5A, 32'h1FFF);
        add(0, 2, 0, 32'h0000_7FFC, 32'h0,         32'hA5A5_5A5A, 0, 4'b0000, 32'h0,         32'h1FFF);
        add(0, 3, 0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1, 4'b0000, 32'h0,         32'd0);
        add(0, 2, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1, 4'b0000, 32'h0,         32'd0);
        add(1, 1, 0, 32'h0000_0021, 32'h0000_1234, 32'h0000_0000, 1, 4'b0000, 32'h0,         32'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // Backpressure: response held 5 cycles, second request waits behind the handshake.
        bus.rsp_ready_i = 1'b0;
        v = vecs[1];                       // LW 0x10, word 4 now 0x80ADBEEF
        drive_req(v);
        @(posedge clk); #1;
        e.rdata = 32'h80AD_BEEF; e.err = 1'b0; e.lat = 3;
        sb.push_back(e);
        v = vecs[10];                      // LW 0x20 queued behind
        drive_req(v);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.rsp_valid_o) begin lat = k; break; end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        chk("bp latency", lat, e.lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h1);
            chk("bp rdata", bus.rsp_rdata_o, e.rdata);
            chk("bp req_ready", {31'h0, bus.req_ready_o}, 32'h0);
            @(posedge clk); #1;
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp rsp_dropped", {31'h0, bus.rsp_valid_o}, 32'h0);
        chk("bp second_waiting", {31'h0, bus.req_ready_o}, 32'h1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        e.rdata = 32'hBEEF_0000; e.err = 1'b0; e.lat = 3;
        sb.push_back(e);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.rsp_valid_o) begin lat = k; break; end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        chk("bp2 latency", lat, e.lat);
        chk("bp2 rdata", bus.rsp_rdata_o, e.rdata);
        @(posedge clk); #1;

        // Reset landing on the ACCESS cycle of a load.
        drive_req(vecs[1]);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        chk("rst_mid in_access", {31'h0, bus.ram_en_o}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid_o) lat++;
            @(posedge clk); #1;
        end
        chk("rst_mid no_rsp", lat, 0);

        v = vecs[0];
        v.addr = 32'h30; v.wdata = 32'h1122_3344; v.exp_data = 32'h1122_3344; v.exp_waddr = 32'd12;
        run_vec(v, 100);
        v.we = 1'b0; v.exp_rdata = 32'h1122_3344; v.exp_we = 4'b0000;
        run_vec(v, 101);

        chk("sb empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
